// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared state encoding and bit-counter width helper for the serial link.
package piso_tx_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/piso_tx_shreg.sv
// piso_tx_shreg: N-bit shift register with bit counter; load wins over shift.
module piso_tx_shreg
    import piso_tx_pkg::*;
#(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  shift_en,
    input  logic [N-1:0]          din,
    output logic                  dout_bit,
    output logic [cnt_w(N)-1:0]   cnt
);

    logic [N-1:0] sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load_en) begin
            sh  <= din;
            cnt <= '0;
        end else if (shift_en) begin
            sh  <= MSB_FIRST ? {sh[N-2:0], 1'b0} : {1'b0, sh[N-1:1]};
            cnt <= cnt + 1'b1;
        end
    end

    assign dout_bit = MSB_FIRST ? sh[N-1] : sh[0];

endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter with a one-word holding buffer for gapless streaming.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] parallel_in,
    input  logic         en_i,
    output logic         ready,
    output logic         serial_out,
    output logic         serial_valid,
    output logic         first,
    output logic         last
);

    localparam int             CW       = cnt_w(N);
    localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  hold;
    logic          hold_full;
    logic [CW-1:0] cnt;
    logic          dout_bit, acc, at_end, load_en, shift_en, hold_wr;

    // At a word boundary the buffered word has priority over a fresh load.
    always_comb begin
        acc      = load && ready;
        at_end   = state == SHIFT && en_i && cnt == LAST_CNT;
        load_en  = (state == IDLE && acc) || (at_end && (hold_full || acc));
        shift_en = state == SHIFT && en_i && cnt != LAST_CNT;
        hold_wr  = state == SHIFT && acc && !at_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (hold_wr) begin
                hold      <= parallel_in;
                hold_full <= 1'b1;
            end else if (at_end && hold_full) begin
                hold_full <= 1'b0;
            end
            state <= (state == IDLE && acc) ? SHIFT : (at_end && !load_en) ? IDLE : state;
        end
    end

    piso_tx_shreg #(.N(N), .MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .shift_en (shift_en),
        .din      (hold_full ? hold : parallel_in),
        .dout_bit (dout_bit),
        .cnt      (cnt)
    );

    assign ready        = !hold_full;
    assign serial_valid = state == SHIFT;
    assign serial_out   = serial_valid && dout_bit;
    assign first        = serial_valid && cnt == '0;
    assign last         = serial_valid && cnt == LAST_CNT;

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench driving an MSB-first and an LSB-first transmitter with identical stimulus.
module tb_piso_tx;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [N-1:0] parallel_in = '0;
    logic         en_i = 1'b1;
    logic [1:0]   rd, so, sv, fi, la;

    // Expected bit stream per DUT, entries are {bit, first, last}; index 0 is MSB-first.
    logic [2:0] q [2][$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_tx #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in), .en_i(en_i),
        .ready(rd[0]), .serial_out(so[0]), .serial_valid(sv[0]), .first(fi[0]), .last(la[0])
    );

    piso_tx #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in), .en_i(en_i),
        .ready(rd[1]), .serial_out(so[1]), .serial_valid(sv[1]), .first(fi[1]), .last(la[1])
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: ready while at most one word (N bits) is still owed on the wire.
    task automatic cycle(input logic ld, input logic [N-1:0] w, input logic e);
        logic rdy_m;
        @(negedge clk);
        load        = ld;
        parallel_in = w;
        en_i        = e;
        rdy_m       = q[0].size() <= N;
        chk("ready_msb", 8'(rd[0]), 8'(rdy_m));
        chk("ready_lsb", 8'(rd[1]), 8'(rdy_m));
        if (ld && rdy_m)
            for (int i = 0; i < N; i++) begin
                q[0].push_back({w[N-1-i], i == 0, i == N - 1});
                q[1].push_back({w[i], i == 0, i == N - 1});
            end
    endtask

    task automatic do_reset();
        @(negedge clk);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", 8'(sv[d]), 8'd0);
            chk("rst_out", 8'(so[d]), 8'd0);
            chk("rst_first", 8'(fi[d]), 8'd0);
            chk("rst_last", 8'(la[d]), 8'd0);
            chk("rst_ready", 8'(rd[d]), 8'd1);
            q[d].delete();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        initial begin : m
            bit pv;
            pv = 1'b0;
            forever begin
                @(posedge clk);
                if (pv && en_i && !rst && q[g].size() > 0) void'(q[g].pop_front());
                #1;
                if (rst) begin
                    pv = 1'b0;
                end else if (q[g].size() > 0) begin
                    chk($sformatf("valid%0d", g), 8'(sv[g]), 8'd1);
                    chk($sformatf("bit%0d", g), 8'(so[g]), 8'(q[g][0][2]));
                    chk($sformatf("first%0d", g), 8'(fi[g]), 8'(q[g][0][1]));
                    chk($sformatf("last%0d", g), 8'(la[g]), 8'(q[g][0][0]));
                    pv = 1'b1;
                end else begin
                    chk($sformatf("idle_valid%0d", g), 8'(sv[g]), 8'd0);
                    chk($sformatf("idle_out%0d", g), 8'(so[g]), 8'd0);
                    pv = 1'b0;
                end
            end
        end
    end

    initial begin
        #1;
        chk("por_ready", 8'(rd), 8'b11);
        chk("por_valid", 8'(sv), 8'b00);
        @(negedge clk);
        rst = 1'b0;
        // single word
        cycle(1'b1, 4'b1011, 1'b1);
        repeat (5) cycle(1'b0, 4'b0000, 1'b1);
        // back-to-back
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b1, 4'b0110, 1'b1);
        repeat (9) cycle(1'b0, 4'b0000, 1'b1);
        // stall on the second bit
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        repeat (6) cycle(1'b0, 4'b0000, 1'b1);
        // overrun while the buffer is full
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b1, 4'b0110, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b1, 4'b1111, 1'b1);
        repeat (9) cycle(1'b0, 4'b0000, 1'b1);
        // asynchronous reset mid-word, then a clean word
        cycle(1'b1, 4'b1011, 1'b1);
        cycle(1'b1, 4'b0110, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        do_reset();
        cycle(1'b1, 4'b0101, 1'b1);
        repeat (6) cycle(1'b0, 4'b0000, 1'b1);
        // randomized traffic with stalls
        repeat (400)
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
        repeat (20) cycle(1'b0, 4'b0000, 1'b1);
        chk("drain_msb", 8'(q[0].size()), 8'd0);
        chk("drain_lsb", 8'(q[1].size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
